// File: rtl/radix4_otf_converter.sv
// -----------------------------------------------------------------------------
// radix4_otf_converter
//
// Purpose:
//   Sequential on-the-fly converter from a radix-4 signed-digit stream (MSD
//   first, digit set {-3..+3}, sign-magnitude encoded) to a two's-complement
//   integer. Two registers are kept: Q (the value so far) and QM (Q - 1).
//   Every digit only shifts and appends into one of them, so no
//   carry-propagate adder is needed per digit.
//
// Parameters:
//   no_of_digits : digits per operand N (N >= 1)
//   radix_bits   : bits per digit; MSB is the sign, the rest is the magnitude
//   radix        : digit radix (4); log2(radix) bits are appended per digit
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous reset, active-low
//   in_valid   in   in_digit is valid
//   in_ready   out  converter accepts a digit this cycle (IDLE/ACC)
//   in_digit   in   sign-magnitude digit: 0mm = +m, 1mm = -m
//   out_valid  out  out_data holds a complete result
//   out_ready  in   downstream accepts out_data
//   out_data   out  signed result, 2N+1 bits, registered
//   err        out  negative-zero flag for the current frame
//
// Build option:
//   RADIX4_OTF_NEG0_CHECK_EN - when defined, a transferred -0 digit (1 00)
//   sets a sticky err that is shown together with out_valid and cleared on the
//   output handshake. When undefined, err is tied low.
// -----------------------------------------------------------------------------
module radix4_otf_converter #(
    parameter int no_of_digits = 8,
    parameter int radix_bits   = 3,
    parameter int radix        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [radix_bits-1:0]   in_digit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*no_of_digits:0] out_data,
    output logic                    err
);

    localparam int W  = 2 * no_of_digits + 1;     // result / Q / QM width
    localparam int LB = $clog2(radix);            // bits appended per digit
    localparam int MB = radix_bits - 1;           // magnitude bits
    localparam int CW = $clog2(no_of_digits + 1); // digit counter width
    localparam logic [CW-1:0] LAST = CW'(no_of_digits - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_qm;
    logic           r_out_valid;

    logic           w_xfer;
    logic           w_hs;
    logic           w_sign;
    logic [MB-1:0]  w_mag;
    logic [W-1:0]   w_q_src;
    logic [W-1:0]   w_qm_src;
    logic [LB-1:0]  w_q_ins;
    logic [LB-1:0]  w_qm_ins;
    logic [W-1:0]   w_q_next;
    logic [W-1:0]   w_qm_next;

    assign in_ready  = (r_state != DONE);
    assign out_valid = r_out_valid;
    // Q is held untouched in DONE, so it doubles as the registered result.
    assign out_data  = r_q;

    assign w_xfer = in_valid & in_ready;
    assign w_hs   = r_out_valid & out_ready;

    assign w_sign = in_digit[radix_bits-1];
    assign w_mag  = in_digit[MB-1:0];

    // Select source register and appended digit for Q and QM.
    //   d > 0 : Q <- Q :d        QM <- Q :d-1
    //   d = 0 : Q <- Q :0        QM <- QM:r-1   (also covers -0)
    //   d < 0 : Q <- QM:r+d      QM <- QM:r-1+d
    always_comb begin
        w_q_src  = r_q;
        w_qm_src = r_qm;
        w_q_ins  = '0;
        w_qm_ins = LB'(radix - 1);
        if (w_mag == '0) begin
            w_q_src  = r_q;
            w_qm_src = r_qm;
            w_q_ins  = '0;
            w_qm_ins = LB'(radix - 1);
        end else if (!w_sign) begin
            w_q_src  = r_q;
            w_qm_src = r_q;
            w_q_ins  = LB'(w_mag);
            w_qm_ins = LB'(w_mag - MB'(1));
        end else begin
            w_q_src  = r_qm;
            w_qm_src = r_qm;
            w_q_ins  = LB'(radix - int'(w_mag));
            w_qm_ins = LB'(radix - 1 - int'(w_mag));
        end
    end

    // Concatenation = shift left by LB and insert; top bits drop off, which is
    // safe because |X| <= radix^N - 1 always fits in W signed bits.
    assign w_q_next  = (w_q_src  << LB) | W'(w_q_ins);
    assign w_qm_next = (w_qm_src << LB) | W'(w_qm_ins);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_q         <= '0;
            r_qm        <= '1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_q     <= w_q_next;
                        r_qm    <= w_qm_next;
                        r_count <= CW'(1);
                        if (no_of_digits == 1) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (w_xfer) begin
                        r_q     <= w_q_next;
                        r_qm    <= w_qm_next;
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (w_hs) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_q         <= '0;
                        r_qm        <= '1;
                        r_count     <= '0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_q         <= '0;
                    r_qm        <= '1;
                    r_count     <= '0;
                end
            endcase
        end
    end

`ifdef RADIX4_OTF_NEG0_CHECK_EN
    logic r_err;
    logic w_neg0;

    assign w_neg0 = w_sign & (w_mag == '0);

    // Sticky per frame; a transfer and a handshake never coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_hs) begin
            r_err <= 1'b0;
        end else if (w_xfer && w_neg0) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
